// File: rtl/fpadd_sched_pkg.sv
// Shared types and constants for the floating-point adder scheduler.
// The state encoding, the stage-counter width and the float word type
// live here so the top, the interface and the bench agree on them.
package fpadd_sched_pkg;

  // Stage counter width; bounds STAGE_CYCLES to 1..15.
  localparam int STAGE_CNT_W = 4;

  // One IEEE-754 single-precision word.
  typedef logic [31:0] float32_t;

  // Scheduler FSM states.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ALIGN = 3'd1,
    ST_ADD   = 3'd2,
    ST_NORM  = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  // Stage strobes for a given state, packed as {norm, add, align}.
  // At most one bit is ever set; IDLE and DONE give all zeros.
  function automatic logic [2:0] stage_strobes(input logic [2:0] st);
    logic [2:0] s;
    s = 3'b000;
    if (st == ST_ALIGN) s = 3'b001;
    if (st == ST_ADD)   s = 3'b010;
    if (st == ST_NORM)  s = 3'b100;
    return s;
  endfunction

endpackage

// File: rtl/fpadd_scheduler_if.sv
// Bundle of the requester, datapath and response signals of the scheduler.
// The scheduler uses the slave view; its environment uses the master view.
interface fpadd_scheduler_if;
  import fpadd_sched_pkg::*;

  // Requester 0 and 1
  logic     req0_valid;
  logic     req0_ready;
  float32_t req0_a;
  float32_t req0_b;
  logic     req1_valid;
  logic     req1_ready;
  float32_t req1_a;
  float32_t req1_b;

  // Shared adder datapath
  float32_t dp_a;
  float32_t dp_b;
  logic     dp_align_en;
  logic     dp_add_en;
  logic     dp_norm_en;
  logic     dp_special;
  float32_t dp_result;

  // Response channel and statistics
  logic        rsp_valid;
  logic        rsp_ready;
  float32_t    rsp_result;
  logic        rsp_id;
  logic [15:0] op_count;

  modport slave (
    input  req0_valid, req0_a, req0_b,
    input  req1_valid, req1_a, req1_b,
    input  dp_special, dp_result, rsp_ready,
    output req0_ready, req1_ready,
    output dp_a, dp_b, dp_align_en, dp_add_en, dp_norm_en,
    output rsp_valid, rsp_result, rsp_id, op_count
  );

  modport master (
    output req0_valid, req0_a, req0_b,
    output req1_valid, req1_a, req1_b,
    output dp_special, dp_result, rsp_ready,
    input  req0_ready, req1_ready,
    input  dp_a, dp_b, dp_align_en, dp_add_en, dp_norm_en,
    input  rsp_valid, rsp_result, rsp_id, op_count
  );

endinterface

// File: rtl/fpadd_scheduler_rr_arbiter2.sv
// Two-way round-robin arbiter. A lone request is granted directly; when
// both request, the requester that was not granted last time wins.
// Grant is one-hot (or zero when disabled or nobody requests).
module rr_arbiter2 (
  input  logic [1:0] req_i,
  input  logic       en_i,
  input  logic       last_grant_i,
  output logic [1:0] grant_o
);

  // Combinational grant selection
  always_comb begin
    grant_o = 2'b00;
    if (en_i) begin
      case (req_i)
        2'b01:   grant_o = 2'b01;
        2'b10:   grant_o = 2'b10;
        2'b11:   grant_o = last_grant_i ? 2'b01 : 2'b10;
        default: grant_o = 2'b00;
      endcase
    end
  end

endmodule

// File: rtl/fpadd_scheduler.sv
// Scheduler that shares one three-stage FP adder datapath between two
// requesters. One operation at a time walks IDLE -> ALIGN -> ADD -> NORM ->
// DONE; each datapath stage strobe is held for STAGE_CYCLES cycles.
// Optional feature: define SPECIAL_FASTPATH_EN to let a special operand
// (flagged by dp_special in the first ALIGN cycle) skip the ADD stage.
module fpadd_scheduler
  import fpadd_sched_pkg::*;
#(
  parameter int STAGE_CYCLES = 1
) (
  input logic               clk,
  input logic               reset,
  fpadd_scheduler_if.slave  bus
);

  localparam logic [2:0] IDLE  = ST_IDLE;
  localparam logic [2:0] ALIGN = ST_ALIGN;
  localparam logic [2:0] ADD   = ST_ADD;
  localparam logic [2:0] NORM  = ST_NORM;
  localparam logic [2:0] DONE  = ST_DONE;

  localparam logic [STAGE_CNT_W-1:0] CNT_LAST = (STAGE_CNT_W)'(STAGE_CYCLES - 1);
  localparam logic [STAGE_CNT_W-1:0] CNT_ONE  = (STAGE_CNT_W)'(1);

  logic [2:0]             state_q, state_d;
  logic [STAGE_CNT_W-1:0] cnt_q, cnt_d;
  float32_t               a_q, b_q, result_q;
  logic                   id_q;
  logic                   last_grant_q;
  logic [15:0]            op_count_q;

  logic [1:0] grant;
  logic       accept;
  logic       stage_last;
  logic       fast_skip;
  logic       rsp_done;

  rr_arbiter2 u_arb (
    .req_i        ({bus.req1_valid, bus.req0_valid}),
    .en_i         (state_q == IDLE),
    .last_grant_i (last_grant_q),
    .grant_o      (grant)
  );

  // The arbiter only grants a valid requester, so a grant is an accept.
  assign accept     = |grant;
  assign stage_last = (cnt_q == CNT_LAST);
  assign rsp_done   = (state_q == DONE) && bus.rsp_ready;

`ifdef SPECIAL_FASTPATH_EN
  // Special operands only need normalisation; decided on the first ALIGN cycle.
  assign fast_skip = bus.dp_special && (cnt_q == '0);
`else
  // Without the fast path the special flag has no effect.
  assign fast_skip = 1'b0 & bus.dp_special;
`endif

  // Next-state and stage-counter logic; the counter restarts on every state entry
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (accept) state_d = ALIGN;
      end
      ALIGN: begin
        if (fast_skip) begin
          state_d = NORM;
          cnt_d   = '0;
        end else if (stage_last) begin
          state_d = ADD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ADD: begin
        if (stage_last) begin
          state_d = NORM;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      NORM: begin
        if (stage_last) begin
          state_d = DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      DONE: begin
        cnt_d = '0;
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // FSM state and stage counter registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Operand and requester-id capture on accept
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q  <= '0;
      b_q  <= '0;
      id_q <= 1'b0;
    end else if (accept) begin
      a_q  <= grant[1] ? bus.req1_a : bus.req0_a;
      b_q  <= grant[1] ? bus.req1_b : bus.req0_b;
      id_q <= grant[1];
    end
  end

  // Datapath result captured on the last NORM cycle, held through DONE
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result_q <= '0;
    end else if ((state_q == NORM) && stage_last) begin
      result_q <= bus.dp_result;
    end
  end

  // Completion bookkeeping when the response is taken
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_count_q   <= '0;
      last_grant_q <= 1'b1;
    end else if (rsp_done) begin
      op_count_q   <= op_count_q + 16'd1;
      last_grant_q <= id_q;
    end
  end

  assign bus.req0_ready = grant[0];
  assign bus.req1_ready = grant[1];
  assign bus.dp_a       = a_q;
  assign bus.dp_b       = b_q;
  assign {bus.dp_norm_en, bus.dp_add_en, bus.dp_align_en} = stage_strobes(state_q);
  assign bus.rsp_valid  = (state_q == DONE);
  assign bus.rsp_result = result_q;
  assign bus.rsp_id     = id_q;
  assign bus.op_count   = op_count_q;

endmodule

// File: tb/tb_fpadd_scheduler.sv
// Directed bench for fpadd_scheduler: one instance at STAGE_CYCLES=1 and
// one at STAGE_CYCLES=3. Expected values are hand-computed constants.
// Build with SPECIAL_FASTPATH_EN defined to exercise the ADD-skip path.
module tb_fpadd_scheduler;

  logic clk = 1'b0;
  logic rst1;
  logic rst3;
  int   n_cmp = 0;
  int   n_err = 0;
  int   exp_ops = 0;

  always #5 clk = ~clk;

  fpadd_scheduler_if if1();
  fpadd_scheduler_if if3();

  fpadd_scheduler #(.STAGE_CYCLES(1)) u_dut1 (.clk(clk), .reset(rst1), .bus(if1.slave));
  fpadd_scheduler #(.STAGE_CYCLES(3)) u_dut3 (.clk(clk), .reset(rst3), .bus(if3.slave));

  // Datapath model of the special-operand flag: exponent all ones, or zero.
  function automatic logic is_special(input logic [31:0] f);
    return (f[30:23] == 8'hFF) || (f[30:0] == 31'd0);
  endfunction

  assign if1.dp_special = is_special(if1.dp_a) || is_special(if1.dp_b);
  assign if3.dp_special = 1'b0;

`ifdef SPECIAL_FASTPATH_EN
  localparam int FAST_LAT = 3;
  localparam int FAST_ADD = 0;
`else
  localparam int FAST_LAT = 4;
  localparam int FAST_ADD = 1;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one request on the STAGE_CYCLES=1 instance and wait for rsp_valid.
  // Called right after a falling edge; returns at the falling edge where
  // rsp_valid was seen (or the bound expired). lat counts falling edges
  // after the accepting rising edge.
  task automatic run_op(input logic id, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] res, output int lat, output int add_seen);
    logic ok;
    ok = 1'b0;
    lat = 0;
    add_seen = 0;
    if1.dp_result = res;
    if (id) begin
      if1.req1_valid = 1'b1; if1.req1_a = a; if1.req1_b = b;
    end else begin
      if1.req0_valid = 1'b1; if1.req0_a = a; if1.req0_b = b;
    end
    for (int i = 0; i < 30; i++) begin
      #1;
      if ((id ? if1.req1_ready : if1.req0_ready) == 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("accept", {31'd0, ok}, 32'd1);
    if (ok) begin
      @(posedge clk);
      #1;
    end
    if1.req0_valid = 1'b0;
    if1.req1_valid = 1'b0;
    if (!ok) return;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        check("dp_a", if1.dp_a, a);
        check("dp_b", if1.dp_b, b);
      end
      if (if1.dp_add_en) add_seen++;
    end while (!if1.rsp_valid && lat < 40);
    check("rsp_result", if1.rsp_result, res);
    check("rsp_id", {31'd0, if1.rsp_id}, {31'd0, id});
    $display("op id=%0d a=%h b=%h result=%h latency=%0d", id, a, b, if1.rsp_result, lat);
  endtask

  // Take the pending response with a one-cycle rsp_ready pulse.
  task automatic take_rsp();
    if1.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    if1.rsp_ready = 1'b0;
    @(negedge clk);
    exp_ops++;
    check("op_count", {16'd0, if1.op_count}, exp_ops);
  endtask

  initial begin : stim
    int lat, add_seen, bad, n_acc, both_rdy, last_cyc;
    int grant_id[4];
    int gap[4];
    int cnt_al, cnt_ad, cnt_no, first_al, first_ad, first_no, overlap;
    logic ok3;

    rst1 = 1'b1; rst3 = 1'b1;
    if1.req0_valid = 1'b0; if1.req0_a = '0; if1.req0_b = '0;
    if1.req1_valid = 1'b0; if1.req1_a = '0; if1.req1_b = '0;
    if1.dp_result = '0; if1.rsp_ready = 1'b0;
    if3.req0_valid = 1'b0; if3.req0_a = '0; if3.req0_b = '0;
    if3.req1_valid = 1'b0; if3.req1_a = '0; if3.req1_b = '0;
    if3.dp_result = '0; if3.rsp_ready = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state
    check("rst_rsp_valid", {31'd0, if1.rsp_valid}, 32'd0);
    check("rst_strobes", {29'd0, if1.dp_norm_en, if1.dp_add_en, if1.dp_align_en}, 32'd0);
    check("rst_op_count", {16'd0, if1.op_count}, 32'd0);
    check("rst_rsp_result", if1.rsp_result, 32'd0);
    check("rst_dp_a", if1.dp_a, 32'd0);
    rst1 = 1'b0; rst3 = 1'b0;
    @(negedge clk);
    check("idle_ready", {30'd0, if1.req1_ready, if1.req0_ready}, 32'd0);

    // Single request: 1.0 + 2.0 = 3.0
    run_op(1'b0, 32'h3F800000, 32'h40000000, 32'h40400000, lat, add_seen);
    check("latency_basic", lat, 32'd4);
    check("add_seen_basic", add_seen, 32'd1);
    take_rsp();

    // Both requesters valid from reset: grants alternate 0,1,0,1 every 5 cycles
    rst1 = 1'b1;
    @(negedge clk);
    rst1 = 1'b0;
    exp_ops = 0;
    if1.dp_result = 32'h41200000;
    if1.req0_valid = 1'b1; if1.req0_a = 32'h40A00000; if1.req0_b = 32'h40A00000;
    if1.req1_valid = 1'b1; if1.req1_a = 32'h40400000; if1.req1_b = 32'h40E00000;
    if1.rsp_ready = 1'b1;
    n_acc = 0; both_rdy = 0; last_cyc = 0;
    for (int c = 0; c < 60 && n_acc < 4; c++) begin
      #1;
      if (if1.req0_ready && if1.req1_ready) both_rdy++;
      if (if1.req0_ready || if1.req1_ready) begin
        grant_id[n_acc] = if1.req1_ready ? 1 : 0;
        gap[n_acc] = c - last_cyc;
        last_cyc = c;
        n_acc++;
        $display("grant requester=%0d cycle=%0d", grant_id[n_acc-1], c);
      end
      @(negedge clk);
    end
    check("rr_accepts", n_acc, 32'd4);
    check("rr_grant0", grant_id[0], 32'd0);
    check("rr_grant1", grant_id[1], 32'd1);
    check("rr_grant2", grant_id[2], 32'd0);
    check("rr_grant3", grant_id[3], 32'd1);
    check("rr_gap1", gap[1], 32'd5);
    check("rr_gap3", gap[3], 32'd5);
    check("rr_both_ready", both_rdy, 32'd0);
    // Fourth operation accepted but not yet finished: three completed
    check("rr_op_count", {16'd0, if1.op_count}, 32'd3);
    if1.req0_valid = 1'b0;
    if1.req1_valid = 1'b0;
    repeat (6) @(negedge clk);
    if1.rsp_ready = 1'b0;
    exp_ops = 4;
    check("rr_op_count_end", {16'd0, if1.op_count}, 32'd4);

    // Stall in DONE for 10 cycles: 1.5 + 2.5 = 4.0 from requester 1
    run_op(1'b1, 32'h3FC00000, 32'h40200000, 32'h40800000, lat, add_seen);
    check("latency_stall", lat, 32'd4);
    if1.req0_valid = 1'b1; if1.req0_a = 32'h3F800000; if1.req0_b = 32'h3F800000;
    if1.dp_result = 32'hDEADBEEF;
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (!if1.rsp_valid || if1.rsp_result !== 32'h40800000 || if1.rsp_id !== 1'b1 ||
          if1.req0_ready || if1.req1_ready || if1.dp_align_en)
        bad++;
    end
    check("stall_stable", bad, 32'd0);
    if1.req0_valid = 1'b0;
    take_rsp();

    // Reset pulsed during ADD aborts the operation
    if1.dp_result = 32'h40400000;
    if1.req0_valid = 1'b1; if1.req0_a = 32'h3F800000; if1.req0_b = 32'h40000000;
    #1;
    check("abort_ready", {31'd0, if1.req0_ready}, 32'd1);
    @(posedge clk);
    #1;
    if1.req0_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("abort_in_add", {31'd0, if1.dp_add_en}, 32'd1);
    rst1 = 1'b1;
    #1;
    check("abort_strobes", {29'd0, if1.dp_norm_en, if1.dp_add_en, if1.dp_align_en}, 32'd0);
    check("abort_op_count", {16'd0, if1.op_count}, 32'd0);
    check("abort_rsp_valid", {31'd0, if1.rsp_valid}, 32'd0);
    check("abort_dp_a", if1.dp_a, 32'd0);
    check("abort_rsp_id", {31'd0, if1.rsp_id}, 32'd0);
    @(negedge clk);
    rst1 = 1'b0;
    exp_ops = 0;
    bad = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (if1.rsp_valid || if1.dp_align_en || if1.dp_add_en || if1.dp_norm_en) bad++;
    end
    check("abort_no_rsp", bad, 32'd0);
    run_op(1'b0, 32'h3F800000, 32'h40000000, 32'h40400000, lat, add_seen);
    check("latency_after_abort", lat, 32'd4);
    take_rsp();

    // Special operand (+inf + 1.0): ADD skipped only with the fast path
    run_op(1'b0, 32'h7F800000, 32'h3F800000, 32'h7F800000, lat, add_seen);
    check("latency_special", lat, FAST_LAT);
    check("add_seen_special", add_seen, FAST_ADD);
    take_rsp();

    // STAGE_CYCLES=3 instance: each strobe held 3 cycles, no overlap
    if3.dp_result = 32'h40400000;
    if3.req0_valid = 1'b1; if3.req0_a = 32'h3F800000; if3.req0_b = 32'h40000000;
    ok3 = 1'b0;
    for (int i = 0; i < 30; i++) begin
      #1;
      if (if3.req0_ready) begin
        ok3 = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("s3_accept", {31'd0, ok3}, 32'd1);
    @(posedge clk);
    #1;
    if3.req0_valid = 1'b0;
    lat = 0; cnt_al = 0; cnt_ad = 0; cnt_no = 0; overlap = 0;
    first_al = 0; first_ad = 0; first_no = 0;
    do begin
      @(negedge clk);
      lat++;
      if (int'(if3.dp_align_en) + int'(if3.dp_add_en) + int'(if3.dp_norm_en) > 1) overlap++;
      if (if3.dp_align_en) begin cnt_al++; if (first_al == 0) first_al = lat; end
      if (if3.dp_add_en)   begin cnt_ad++; if (first_ad == 0) first_ad = lat; end
      if (if3.dp_norm_en)  begin cnt_no++; if (first_no == 0) first_no = lat; end
    end while (!if3.rsp_valid && lat < 60);
    $display("op stage3 a=3f800000 b=40000000 result=%h latency=%0d", if3.rsp_result, lat);
    check("s3_align_cycles", cnt_al, 32'd3);
    check("s3_add_cycles", cnt_ad, 32'd3);
    check("s3_norm_cycles", cnt_no, 32'd3);
    check("s3_align_first", first_al, 32'd1);
    check("s3_add_first", first_ad, 32'd4);
    check("s3_norm_first", first_no, 32'd7);
    check("s3_overlap", overlap, 32'd0);
    check("s3_latency", lat, 32'd10);
    check("s3_result", if3.rsp_result, 32'h40400000);
    if3.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    if3.rsp_ready = 1'b0;
    @(negedge clk);
    check("s3_op_count", {16'd0, if3.op_count}, 32'd1);
    check("s3_rsp_valid_low", {31'd0, if3.rsp_valid}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Global watchdog so the run always terminates
  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench timeout");
  end

endmodule

// File: doc/fpadd_scheduler.md
FPADD_SCHEDULER -- requirements
Module: fpadd_scheduler

Interface
REQ-001 The module SHALL declare parameter STAGE_CYCLES, default 1, which sets the number of cycles each datapath stage enable is held (legal range 1..15).
REQ-002 The module SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-003 The module SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 The module SHALL have ports req0_valid/req1_valid, input, 1 bit each: the requester holds an operand pair.
REQ-005 The module SHALL have ports req0_ready/req1_ready, output, 1 bit each: the request is accepted this cycle.
REQ-006 The module SHALL have ports req0_a, req0_b, req1_a and req1_b, input, 32 bits each: IEEE-754 single operands.
REQ-007 The module SHALL have ports dp_a and dp_b, output, 32 bits each: operands to the shared adder datapath.
REQ-008 The module SHALL have ports dp_align_en, dp_add_en and dp_norm_en, output, 1 bit each: stage strobes.
REQ-009 The module SHALL have port dp_special, input, 1 bit: datapath flags an operand as NaN, infinity or zero.
REQ-010 The module SHALL have port dp_result, input, 32 bits: normalized datapath result.
REQ-011 The module SHALL have ports rsp_valid (output, 1), rsp_ready (input, 1), rsp_result (output, 32) and rsp_id (output, 1): response channel; rsp_id identifies the requester.
REQ-012 The module SHALL have port op_count, output, 16 bits: completed-operation counter.

Function
REQ-013 The FSM SHALL have states IDLE, ALIGN, ADD, NORM and DONE; the reset state SHALL be IDLE.
REQ-014 In IDLE, arbitration SHALL be round-robin, with a last_grant register favouring the other requester on a tie.
- reqN_ready SHALL be high only in IDLE and only for the granted requester.
REQ-015 An accept (valid and ready) SHALL capture a, b and the requester id into operand registers; dp_a and dp_b SHALL be driven only from those registers.
REQ-016 ALIGN, ADD and NORM SHALL each last exactly STAGE_CYCLES cycles, timed by a 4-bit stage counter that is cleared on every state entry.
- Exactly one dp_*_en SHALL be high, matching the current state; all strobes SHALL be low in IDLE and DONE.
REQ-017 dp_result SHALL be registered into rsp_result on the last NORM cycle; the FSM SHALL then enter DONE.
REQ-018 In DONE, rsp_valid SHALL be high and rsp_result and rsp_id SHALL be stable until rsp_ready is sampled high.
- On that edge: go to IDLE, increment op_count (16-bit wrap, 0xFFFF to 0x0000) and update last_grant.
REQ-019 Latency with STAGE_CYCLES=1 and no fast path SHALL be: accept edge T, then rsp_valid from cycle T+4; the minimum accept-to-accept interval SHALL be 5 cycles.
REQ-020 Requests arriving outside IDLE SHALL be ignored (ready low); requesters hold valid.
REQ-021 Stall in DONE SHALL be indefinite, with no timeout.

Reset
REQ-022 Reset SHALL force the FSM to IDLE, last_grant to 1, and stage counter, operand registers, rsp_result, rsp_id and op_count to 0; all ready, strobe and valid outputs SHALL be 0.
REQ-023 Reset asserted mid-operation SHALL abort the operation with no response; op_count SHALL not increment.

Configuration
REQ-024 With SPECIAL_FASTPATH_EN defined, dp_special sampled high during the first ALIGN cycle SHALL send the FSM directly to NORM, skipping ADD; latency becomes T+3 at STAGE_CYCLES=1.
- Without the macro, dp_special SHALL be ignored.

Structure
REQ-025 A shared package fpadd_sched_pkg SHALL hold the state enum type, the 4-bit stage-counter width constant and a 32-bit float typedef.
REQ-026 The round-robin arbiter SHALL be a sub-module rr_arbiter2 (inputs: 2 requests, enable and last_grant; output: one-hot grant).

Verification
REQ-027 The bench SHALL cover these directed scenarios:
- req0: a=0x3F800000, b=0x40000000 at T, datapath model returns 0x40400000 -> rsp_valid at T+4, rsp_result=0x40400000, rsp_id=0, op_count=1.
- req0 and req1 both valid from reset -> req0 granted first, req1 next; after 4 ops the grants alternate 0,1,0,1.
- STAGE_CYCLES=3 -> each dp_*_en held exactly 3 cycles, with no overlap.
- rsp_ready held low 10 cycles in DONE -> rsp_valid and rsp_result stable; no new accept.
- reset pulsed during ADD -> outputs return to reset values; the next request completes normally.
- SPECIAL_FASTPATH_EN defined, a=0x7F800000, dp_special=1 -> dp_add_en never high; rsp_valid at T+3.
